cic_rate_ctrl: RTL and testbench



---
 rtl/cic_rate_ctrl.sv | 118 +++++++++++
 tb/tb_cic_rate_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - rate/sequencing controller for the 3-stage CIC decimator.
// Optional sticky settle-done interrupt: define RATE_IRQ_EN.
module cic_rate_ctrl #(
  parameter int RATE0_LOG2 = 4,
  parameter int CNT_W      = 8,
  parameter int SETTLE_N   = 3
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] srat,
`ifdef RATE_IRQ_EN
  input  logic       irq_clr,
  output logic       irq,
`endif
  output logic [1:0] cic_srat,
  output logic       cic_clr,
  output logic       dec_stb,
  output logic       dout_vld,
  output logic       busy
);

  localparam int SW = $clog2(SETTLE_N + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] phase, r_last;
  logic [SW-1:0]    settle_cnt;
  logic             mismatch, ph_wrap, settle_done, vld_nxt;

  assign mismatch    = (srat != cic_srat);
  assign r_last      = CNT_W'((1 << (RATE0_LOG2 + int'(cic_srat))) - 1);
  assign ph_wrap     = (phase == r_last);
  assign settle_done = (settle_cnt == SW'(SETTLE_N - 1));

  // dec_stb is registered, so decisions about a strobe are taken on the edge
  // that ends the strobe cycle; that same edge raises dout_vld.
  always_comb begin
    state_nxt = state;
    vld_nxt   = 1'b0;
    case (state)
      S_IDLE:   if (en) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (mismatch) state_nxt = S_CLEAR;
        else if (dec_stb && settle_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (dec_stb) begin
          vld_nxt = 1'b1;
          if (mismatch) state_nxt = S_CLEAR;
        end else if (mismatch) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dec_stb) begin
          vld_nxt   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!en) begin
      state_nxt = S_IDLE;
      vld_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= '0;
      settle_cnt <= '0;
      cic_srat   <= 2'd0;
      cic_clr    <= 1'b0;
      dec_stb    <= 1'b0;
      dout_vld   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      dout_vld <= vld_nxt;
      cic_clr  <= (state_nxt == S_CLEAR);
      if (state_nxt == S_CLEAR) begin
        cic_srat   <= srat;
        phase      <= '0;
        settle_cnt <= '0;
        dec_stb    <= 1'b0;
        busy       <= 1'b1;
      end else if (state_nxt == S_IDLE) begin
        phase      <= '0;
        settle_cnt <= '0;
        dec_stb    <= 1'b0;
        busy       <= 1'b0;
      end else begin
        phase   <= ph_wrap ? '0 : phase + CNT_W'(1);
        dec_stb <= ph_wrap;
        if (state == S_SETTLE && dec_stb) settle_cnt <= settle_cnt + SW'(1);
        // busy stays up through RUN entry until the first settled sample leaves
        busy <= (state_nxt != S_RUN) || (busy && !vld_nxt);
      end
    end
  end

`ifdef RATE_IRQ_EN
  always_ff @(posedge clki) begin
    if (!rst_n) irq <= 1'b0;
    else if (state == S_SETTLE && state_nxt == S_RUN) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - directed self-checking bench for cic_rate_ctrl.
module tb_cic_rate_ctrl;
  logic       clki = 1'b0;
  logic       rst_n, en;
  logic [1:0] srat;
  logic [1:0] cic_srat;
  logic       cic_clr, dec_stb, dout_vld, busy;
`ifdef RATE_IRQ_EN
  logic       irq_clr, irq;
`endif

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int stb_cnt = 0;
  int n, v0, s0;

  always #5 clki = ~clki;

  cic_rate_ctrl dut (
    .clki(clki), .rst_n(rst_n), .en(en), .srat(srat),
`ifdef RATE_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .cic_srat(cic_srat), .cic_clr(cic_clr), .dec_stb(dec_stb),
    .dout_vld(dout_vld), .busy(busy)
  );

  task automatic tick();
    @(posedge clki);
    @(negedge clki);
    if (dout_vld) vld_cnt++;
    if (dec_stb) stb_cnt++;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // sel: 0 = dec_stb, 1 = dout_vld; returns cycles waited (max on timeout)
  task automatic wait_for(input int sel, input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!((sel == 0) ? dec_stb : dout_vld) && cyc < max);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {cic_srat, cic_clr, dec_stb, dout_vld, busy}
  function automatic int outs();
    return int'({cic_srat, cic_clr, dec_stb, dout_vld, busy});
  endfunction

  function automatic int pk(input int sr, input int clr, input int stb, input int vld, input int bsy);
    return (sr << 4) | (clr << 3) | (stb << 2) | (vld << 1) | bsy;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; srat = 2'd0;
`ifdef RATE_IRQ_EN
    irq_clr = 1'b0;
`endif
    @(negedge clki);
    ticks(3);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), 0);

    // start-up at R=16
    en = 1'b1;
    tick();
    chk("start_clr", outs(), pk(0, 1, 0, 0, 1));
    v0 = vld_cnt;
    wait_for(0, 40, n); chk("stb1_gap", n, 16);
    wait_for(0, 40, n); chk("stb2_gap", n, 16);
    wait_for(0, 40, n); chk("stb3_gap", n, 16);
    wait_for(0, 40, n); chk("stb4_gap", n, 16);
    chk("busy_before_vld", int'(busy), 1);
    chk("no_settle_vld", vld_cnt - v0, 0);
    tick();
    chk("first_vld", outs(), pk(0, 0, 0, 1, 0));
`ifdef RATE_IRQ_EN
    chk("irq_set", int'(irq), 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    chk("irq_clr", int'(irq), 0);
    wait_for(0, 40, n);
    tick();
`endif
    wait_for(1, 40, n); chk("vld_period", n, 16);

    // rate change mid-period: drain, then clear at R=64
    ticks(5);
    srat = 2'd2;
    tick();
    chk("drain_enter", outs(), pk(0, 0, 0, 0, 1));
    wait_for(0, 40, n); chk("drain_stb_gap", n, 9);
    tick();
    chk("drain_vld_clr", outs(), pk(2, 1, 0, 1, 1));
    v0 = vld_cnt;
    wait_for(0, 200, n); chk("r64_stb1", n, 64);
    wait_for(1, 400, n); chk("r64_first_vld", n, 193);
    chk("r64_vld_count", vld_cnt - v0, 1);
    chk("r64_busy", int'(busy), 0);

    // change on the strobe cycle: no drain
    wait_for(0, 200, n); chk("r64_stb_gap", n, 63);
    srat = 2'd1;
    tick();
    chk("stb_change", outs(), pk(1, 1, 0, 1, 1));

    // change during settle at R=32, then restart at R=128
    wait_for(0, 100, n); chk("r32_stb1", n, 32);
    srat = 2'd3;
    tick();
    chk("settle_change", outs(), pk(3, 1, 0, 0, 1));
    v0 = vld_cnt;
    s0 = stb_cnt;
    for (int i = 0; i < 3; i++) begin
      wait_for(0, 300, n); chk("r128_settle_gap", n, 128);
    end
    chk("r128_no_vld", vld_cnt - v0, 0);
    wait_for(1, 300, n); chk("r128_first_vld", n, 129);

    // en drop in RUN
    ticks(3);
    en = 1'b0;
    tick();
    chk("en_drop", outs(), pk(3, 0, 0, 0, 0));
    v0 = vld_cnt;
    s0 = stb_cnt;
    ticks(200);
    chk("idle_quiet", (vld_cnt - v0) + (stb_cnt - s0), 0);
    chk("idle_srat_kept", int'(cic_srat), 3);

    // en drop on a strobe edge drops the scheduled dout_vld
    srat = 2'd0;
    en = 1'b1;
    tick();
    chk("restart_clr", outs(), pk(0, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++) wait_for(0, 40, n);
    chk("restart_stb4_gap", n, 16);
    v0 = vld_cnt;
    en = 1'b0;
    tick();
    chk("en_drop_on_stb", outs(), pk(0, 0, 0, 0, 0));
    chk("dropped_vld", vld_cnt - v0, 0);

    // reset in DRAIN
    en = 1'b1;
    tick();
    wait_for(1, 200, n); chk("restart_first_vld", n, 65);
    ticks(2);
    srat = 2'd1;
    tick();
    chk("drain2_enter", outs(), pk(0, 0, 0, 0, 1));
    srat = 2'd2;
    ticks(3);
    rst_n = 1'b0;
    tick();
    chk("reset_in_drain", outs(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
